seg_scan_drive: RTL and testbench



---
 rtl/seg_scan_drive_pkg.sv | 27 ++
 rtl/hex2seg.sv | 30 +++
 rtl/seg_scan_drive.sv | 129 ++++++++++++
 tb/tb_seg_scan_drive.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_scan_drive_pkg.sv
// Shared definitions for the seven-segment scan driver: FSM encodings,
// blank pattern, segment bit positions and the counter sizing helper.
package seg_scan_drive_pkg;

   localparam logic [0:0] ST_BLANK = 1'b0;
   localparam logic [0:0] ST_SHOW  = 1'b1;

   localparam logic [7:0] SEG_BLANK = 8'hFF;

   // Bit positions on the active-low segment bus {dp,g,f,e,d,c,b,a}
   localparam int SEG_A  = 0;
   localparam int SEG_B  = 1;
   localparam int SEG_C  = 2;
   localparam int SEG_D  = 3;
   localparam int SEG_E  = 4;
   localparam int SEG_F  = 5;
   localparam int SEG_G  = 6;
   localparam int SEG_DP = 7;

   // Width of a counter that must reach max(a,b)-1; never narrower than one bit.
   function automatic int cnt_width(input int a, input int b);
      int m;
      m = (a > b) ? a : b;
      return (m > 1) ? $clog2(m) : 1;
   endfunction

endpackage

// File: rtl/hex2seg.sv
// Hex nibble to active-low seven-segment glyph {g,f,e,d,c,b,a}.
module hex2seg (
   input  logic [3:0] hex,
   output logic [6:0] seg
);

   always_comb begin
      seg = 7'h7F;
      case (hex)
         4'h0: seg = 7'h40;
         4'h1: seg = 7'h79;
         4'h2: seg = 7'h24;
         4'h3: seg = 7'h30;
         4'h4: seg = 7'h19;
         4'h5: seg = 7'h12;
         4'h6: seg = 7'h02;
         4'h7: seg = 7'h78;
         4'h8: seg = 7'h00;
         4'h9: seg = 7'h10;
         4'hA: seg = 7'h08;
         4'hB: seg = 7'h03;
         4'hC: seg = 7'h46;
         4'hD: seg = 7'h21;
         4'hE: seg = 7'h06;
         4'hF: seg = 7'h0E;
         default: seg = 7'h7F;
      endcase
   end

endmodule

// File: rtl/seg_scan_drive.sv
// Eight-digit multiplexed display scanner with blanking gaps and a
// double-buffered digit set that only swaps at frame start.
module seg_scan_drive
   import seg_scan_drive_pkg::*;
#(
   parameter int CLK_DIV   = 50000,
   parameter int BLANK_CYC = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic [31:0] data_in,
   input  logic [7:0]  dp_in,
   input  logic [7:0]  mask_in,
   output logic [2:0]  sel,
   output logic        sel_en,
   output logic [7:0]  seg_out,
   output logic        frame_done
);

   localparam int CW = cnt_width(CLK_DIV, BLANK_CYC);
   localparam logic [CW-1:0] SHOW_LAST  = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);

   logic [0:0]    state_reg, state_next;
   logic [CW-1:0] cnt_reg, cnt_next;
   logic [2:0]    sel_reg, sel_next;
   logic          sel_en_reg, sel_en_next;
   logic [7:0]    seg_reg, seg_next;
   logic          frame_done_reg, frame_done_next;
   logic          frame_start;

   logic [31:0]   pend_data_reg, disp_data_reg;
   logic [7:0]    pend_dp_reg, disp_dp_reg;
   logic [7:0]    pend_mask_reg, disp_mask_reg;
   logic          dirty_reg;

   logic [3:0]    nib;
   logic [6:0]    glyph;
   logic          lit;

   always_comb begin
      state_next      = state_reg;
      cnt_next        = cnt_reg + CW'(1);
      sel_next        = sel_reg;
      frame_done_next = 1'b0;
      frame_start     = 1'b0;
      if (state_reg == ST_BLANK) begin
         if (cnt_reg == BLANK_LAST) begin
            state_next = ST_SHOW;
            cnt_next   = '0;
         end
      end else begin
         if (cnt_reg == SHOW_LAST) begin
            state_next      = ST_BLANK;
            cnt_next        = '0;
            sel_next        = sel_reg + 3'd1;
            frame_done_next = (sel_reg == 3'd7);
            frame_start     = (sel_reg == 3'd7);
         end
      end
   end

   // Outputs are built from next-state values so they change on the same
   // edge as the FSM; display regs are settled since a BLANK precedes SHOW.
   assign nib = disp_data_reg[{sel_next, 2'b00} +: 4];

   hex2seg u_hex2seg (
      .hex (nib),
      .seg (glyph)
   );

   always_comb begin
      lit         = (state_next == ST_SHOW) && disp_mask_reg[sel_next];
      sel_en_next = lit;
      seg_next    = lit ? {~disp_dp_reg[sel_next], glyph} : SEG_BLANK;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= ST_BLANK;
         cnt_reg        <= '0;
         sel_reg        <= 3'd0;
         sel_en_reg     <= 1'b0;
         seg_reg        <= SEG_BLANK;
         frame_done_reg <= 1'b0;
      end else begin
         state_reg      <= state_next;
         cnt_reg        <= cnt_next;
         sel_reg        <= sel_next;
         sel_en_reg     <= sel_en_next;
         seg_reg        <= seg_next;
         frame_done_reg <= frame_done_next;
      end
   end

   // A load coinciding with the frame-start copy lands in pending and stays dirty.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_data_reg <= '0;
         pend_dp_reg   <= '0;
         pend_mask_reg <= '0;
         disp_data_reg <= '0;
         disp_dp_reg   <= '0;
         disp_mask_reg <= '0;
         dirty_reg     <= 1'b0;
      end else begin
         if (frame_start && dirty_reg) begin
            disp_data_reg <= pend_data_reg;
            disp_dp_reg   <= pend_dp_reg;
            disp_mask_reg <= pend_mask_reg;
         end
         if (load) begin
            pend_data_reg <= data_in;
            pend_dp_reg   <= dp_in;
            pend_mask_reg <= mask_in;
            dirty_reg     <= 1'b1;
         end else if (frame_start) begin
            dirty_reg <= 1'b0;
         end
      end
   end

   assign sel        = sel_reg;
   assign sel_en     = sel_en_reg;
   assign seg_out    = seg_reg;
   assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_seg_scan_drive.sv
// Self-checking bench for seg_scan_drive against a frame-position model.
module tb_seg_scan_drive;

   localparam int CLK_DIV   = 4;
   localparam int BLANK_CYC = 2;
   localparam int SLOT      = CLK_DIV + BLANK_CYC;
   localparam int FRAME     = 8 * SLOT;

   logic        clk;
   logic        rst_n;
   logic        load;
   logic [31:0] data_in;
   logic [7:0]  dp_in;
   logic [7:0]  mask_in;
   logic [2:0]  sel;
   logic        sel_en;
   logic [7:0]  seg_out;
   logic        frame_done;

   int errors = 0;
   int checks = 0;

   seg_scan_drive #(.CLK_DIV(CLK_DIV), .BLANK_CYC(BLANK_CYC)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (load),
      .data_in    (data_in),
      .dp_in      (dp_in),
      .mask_in    (mask_in),
      .sel        (sel),
      .sel_en     (sel_en),
      .seg_out    (seg_out),
      .frame_done (frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Segment codes (dp off) for hex digits 0..F.
   logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

   // Model: k = rising edges since reset release; display swaps at k = n*FRAME.
   int          k;
   logic [31:0] m_pdata, m_ddata;
   logic [7:0]  m_pdp, m_ddp, m_pmask, m_dmask;

   task automatic model_reset();
      k = 0;
      m_pdata = '0; m_pdp = '0; m_pmask = '0;
      m_ddata = '0; m_ddp = '0; m_dmask = '0;
   endtask

   function automatic logic [12:0] exp_vec();
      int q, d;
      logic show;
      logic [3:0] n;
      logic [7:0] s;
      q = k % FRAME;
      d = q / SLOT;
      show = ((q % SLOT) >= BLANK_CYC) && m_dmask[d];
      n = m_ddata[d*4 +: 4];
      s = show ? (seg_tab[n] & (m_ddp[d] ? 8'h7F : 8'hFF)) : 8'hFF;
      return {3'(d), show, s, (k > 0) && (q == 0)};
   endfunction

   task automatic tick(input bit ld, input logic [31:0] d, input logic [7:0] dp, input logic [7:0] m);
      load = ld; data_in = d; dp_in = dp; mask_in = m;
      @(posedge clk);
      k++;
      if (k % FRAME == 0) begin
         m_ddata = m_pdata; m_ddp = m_pdp; m_dmask = m_pmask;
      end
      if (ld) begin
         m_pdata = d; m_pdp = dp; m_pmask = m;
      end
      #1;
      load = 1'b0;
   endtask

   task automatic advance_to(input int q);
      do tick(1'b0, '0, '0, '0); while (k % FRAME != q);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({sel, sel_en, seg_out, frame_done} !== {3'd0, 1'b0, 8'hFF, 1'b0}) begin
         errors++;
         $display("FAIL reset_state: got sel=%0d en=%b seg=%h fd=%b, want 0 0 ff 0", sel, sel_en, seg_out, frame_done);
      end
      rst_n = 1'b1;
      model_reset();
      for (int i = 0; i < FRAME; i++) begin
         tick(1'b0, '0, '0, '0);
         checks++;
         if (sel_en !== 1'b0 || sel !== exp_vec()[12:10]) begin
            errors++;
            $display("FAIL reset_dark k=%0d: got sel=%0d en=%b, want sel=%0d en=0", k, sel, sel_en, exp_vec()[12:10]);
         end
      end
      $display("test_reset done k=%0d", k);
   endtask

   task automatic test_single_load();
      int pulses = 0;
      tick(1'b1, 32'h76543210, 8'h00, 8'hFF);
      advance_to(0);
      for (int i = 0; i < 2 * FRAME; i++) begin
         tick(1'b0, '0, '0, '0);
         checks++;
         if ({sel, sel_en, seg_out, frame_done} !== exp_vec()) begin
            errors++;
            $display("FAIL single_load k=%0d: got %h, want %h", k, {sel, sel_en, seg_out, frame_done}, exp_vec());
         end
         if (frame_done) pulses++;
         if (k % FRAME == 2 || k % FRAME == 7 * SLOT + 2) begin
            checks++;
            if (seg_out !== ((k % FRAME == 2) ? 8'hC0 : 8'hF8)) begin
               errors++;
               $display("FAIL single_glyph k=%0d: got %h", k, seg_out);
            end
         end
      end
      checks++;
      if (pulses != 2) begin
         errors++;
         $display("FAIL frame_done_count: got %0d, want 2", pulses);
      end
      $display("test_single_load done pulses=%0d", pulses);
   endtask

   task automatic test_mask_dp();
      tick(1'b1, 32'h000000F8, 8'h01, 8'h05);
      advance_to(0);
      for (int i = 0; i < FRAME; i++) begin
         tick(1'b0, '0, '0, '0);
         checks++;
         if ({sel, sel_en, seg_out, frame_done} !== exp_vec()) begin
            errors++;
            $display("FAIL mask_dp k=%0d: got %h, want %h", k, {sel, sel_en, seg_out, frame_done}, exp_vec());
         end
         if (k % FRAME == 2) begin
            checks++;
            if (seg_out !== 8'h00 || sel_en !== 1'b1) begin
               errors++;
               $display("FAIL mask_dp_digit0: got seg=%h en=%b, want 00 1", seg_out, sel_en);
            end
         end
      end
      $display("test_mask_dp done");
   endtask

   task automatic test_tear_free();
      tick(1'b1, 32'h0, 8'h00, 8'hFF);
      advance_to(0);
      advance_to(3 * SLOT + 2);
      tick(1'b1, 32'hFFFFFFFF, 8'h00, 8'hFF);
      for (int i = 0; i < FRAME + 30; i++) begin
         tick(1'b0, '0, '0, '0);
         checks++;
         if ({sel, sel_en, seg_out, frame_done} !== exp_vec()) begin
            errors++;
            $display("FAIL tear_free k=%0d: got %h, want %h", k, {sel, sel_en, seg_out, frame_done}, exp_vec());
         end
         if (k % FRAME == 7 * SLOT + 2) begin
            checks++;
            if (seg_out !== ((i < FRAME) ? 8'hC0 : 8'h8E)) begin
               errors++;
               $display("FAIL tear_digit7 i=%0d: got %h", i, seg_out);
            end
         end
      end
      $display("test_tear_free done");
   endtask

   task automatic test_collisions();
      logic [31:0] a, b, c;
      a = $urandom; b = $urandom; c = ~b;
      advance_to(5);
      tick(1'b1, a, 8'h00, 8'hFF);
      tick(1'b0, '0, '0, '0);
      tick(1'b1, b, 8'h00, 8'hFF);
      advance_to(FRAME - 1);
      tick(1'b1, c, 8'h00, 8'hFF);
      for (int i = 0; i < 2 * FRAME; i++) begin
         tick(1'b0, '0, '0, '0);
         checks++;
         if ({sel, sel_en, seg_out, frame_done} !== exp_vec()) begin
            errors++;
            $display("FAIL collision k=%0d: got %h, want %h", k, {sel, sel_en, seg_out, frame_done}, exp_vec());
         end
         if (k % FRAME == 2) begin
            checks++;
            if (seg_out !== seg_tab[(i < FRAME) ? b[3:0] : c[3:0]]) begin
               errors++;
               $display("FAIL collision_digit0 i=%0d: got %h", i, seg_out);
            end
         end
      end
      $display("test_collisions done a=%h b=%h c=%h", a, b, c);
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 19) == 0)
            tick(1'b1, $urandom, 8'($urandom), 8'($urandom));
         else
            tick(1'b0, '0, '0, '0);
         checks++;
         if ({sel, sel_en, seg_out, frame_done} !== exp_vec()) begin
            errors++;
            $display("FAIL random k=%0d: got %h, want %h", k, {sel, sel_en, seg_out, frame_done}, exp_vec());
         end
      end
      $display("test_random done");
   endtask

   task automatic test_mid_reset();
      tick(1'b1, 32'h89ABCDEF, 8'hFF, 8'hFF);
      advance_to(0);
      advance_to(5 * SLOT + 2);
      tick(1'b1, 32'h12345678, 8'h00, 8'hFF);
      checks++;
      if (sel !== 3'd5 || sel_en !== 1'b1) begin
         errors++;
         $display("FAIL pre_reset: got sel=%0d en=%b, want 5 1", sel, sel_en);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({sel, sel_en, seg_out, frame_done} !== {3'd0, 1'b0, 8'hFF, 1'b0}) begin
         errors++;
         $display("FAIL mid_reset: got sel=%0d en=%b seg=%h fd=%b, want 0 0 ff 0", sel, sel_en, seg_out, frame_done);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
      for (int i = 0; i < 2 * FRAME; i++) begin
         tick(1'b0, '0, '0, '0);
         checks++;
         if (sel_en !== 1'b0 || seg_out !== 8'hFF || {sel, sel_en, seg_out, frame_done} !== exp_vec()) begin
            errors++;
            $display("FAIL post_reset_dark k=%0d: got %h, want %h", k, {sel, sel_en, seg_out, frame_done}, exp_vec());
         end
      end
      $display("test_mid_reset done");
   endtask

   initial begin
      rst_n = 1'b0; load = 1'b0; data_in = '0; dp_in = '0; mask_in = '0;
      model_reset();
      test_reset();
      test_single_load();
      test_mask_dp();
      test_tear_free();
      test_collisions();
      test_random();
      test_mid_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
